// File: rtl/nios2_system_nios2_oci_dct_sched.sv
// DCT scheduler: round-robin packing of ITM/DTM trace tokens into a 15-slot buffer, drained to the sink.
// Optional stall counter output enabled by defining NIOS2_OCI_DCT_STALL_COUNT_EN.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ACCEPT    | arbitrate and append frames into the buffer
//   FLUSH     | offer buffer to sink, return to ACCEPT after handshake
//   END_FLUSH | final drain of a non-empty buffer at end of test
//   ENDED     | end of test reached, sticky until reset
module nios2_system_nios2_oci_dct_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        itm_req,
    input  logic [7:0]  itm_data,
    input  logic [1:0]  itm_len,
    output logic        itm_ack,
    input  logic        dtm_req,
    input  logic [7:0]  dtm_data,
    input  logic [1:0]  dtm_len,
    output logic        dtm_ack,
    input  logic        flush_req,
    input  logic        test_ending,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        dct_valid,
    input  logic        dct_ready,
    output logic        test_has_ended
`ifdef NIOS2_OCI_DCT_STALL_COUNT_EN
   ,output logic [15:0] dct_stall_count
`endif
);

    typedef enum logic [1:0] {
        ACCEPT    = 2'd0,
        FLUSH     = 2'd1,
        END_FLUSH = 2'd2,
        ENDED     = 2'd3
    } state_t;

    state_t      state;
    logic        rr_ptr;
    logic        end_pending;

    logic        cand_is_itm;
    logic        cand_req;
    logic [1:0]  cand_len;
    logic [7:0]  cand_data;
    logic [7:0]  tok_mask;
    logic [4:0]  sum_count;
    logic        fits;
    logic        grant;
    logic [3:0]  next_count;
    logic [29:0] append_word;
    logic        need_flush;

    always_comb begin
        cand_is_itm = rr_ptr ? (itm_req & ~dtm_req) : itm_req;
        cand_req    = itm_req | dtm_req;
        cand_len    = cand_is_itm ? itm_len  : dtm_len;
        cand_data   = cand_is_itm ? itm_data : dtm_data;
        case (cand_len)
            2'd0:    tok_mask = 8'h03;
            2'd1:    tok_mask = 8'h0F;
            2'd2:    tok_mask = 8'h3F;
            default: tok_mask = 8'hFF;
        endcase
        sum_count   = {1'b0, dct_count} + {3'b000, cand_len} + 5'd1;
        fits        = (sum_count <= 5'd15);
        // No bypass: a blocked candidate stalls the other source too.
        grant       = (state == ACCEPT) && cand_req && fits && !test_ending && !reset;
        itm_ack     = grant & cand_is_itm;
        dtm_ack     = grant & ~cand_is_itm;
        next_count  = grant ? sum_count[3:0] : dct_count;
        append_word = {22'b0, cand_data & tok_mask} << {dct_count, 1'b0};
        need_flush  = (next_count == 4'd15)
                    || (cand_req && !fits && (dct_count != 4'd0))
                    || (flush_req && (next_count != 4'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ACCEPT;
            dct_buffer     <= '0;
            dct_count      <= '0;
            rr_ptr         <= 1'b0;
            end_pending    <= 1'b0;
            dct_valid      <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (grant) begin
                        dct_buffer <= dct_buffer | append_word;
                        dct_count  <= next_count;
                        rr_ptr     <= cand_is_itm;
                    end
                    if (test_ending) begin
                        if (dct_count != 4'd0) begin
                            state     <= END_FLUSH;
                            dct_valid <= 1'b1;
                        end else begin
                            state          <= ENDED;
                            test_has_ended <= 1'b1;
                        end
                    end else if (need_flush) begin
                        state     <= FLUSH;
                        dct_valid <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (dct_ready) begin
                        dct_buffer  <= '0;
                        dct_count   <= '0;
                        dct_valid   <= 1'b0;
                        end_pending <= 1'b0;
                        if (end_pending || test_ending) begin
                            state          <= ENDED;
                            test_has_ended <= 1'b1;
                        end else begin
                            state <= ACCEPT;
                        end
                    end else if (test_ending) begin
                        end_pending <= 1'b1;
                    end
                end
                END_FLUSH: begin
                    if (dct_ready) begin
                        dct_buffer     <= '0;
                        dct_count      <= '0;
                        dct_valid      <= 1'b0;
                        state          <= ENDED;
                        test_has_ended <= 1'b1;
                    end
                end
                default: begin
                    test_has_ended <= 1'b1;
                end
            endcase
        end
    end

`ifdef NIOS2_OCI_DCT_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dct_stall_count <= '0;
        end else if ((itm_req || dtm_req) && !grant && (dct_stall_count != 16'hFFFF)) begin
            dct_stall_count <= dct_stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nios2_system_nios2_oci_dct_sched.sv
// Directed bench for the DCT scheduler with a queue-based reference model checked every cycle.
module tb_nios2_system_nios2_oci_dct_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        itm_req, dtm_req, flush_req, test_ending, dct_ready;
    logic [7:0]  itm_data, dtm_data;
    logic [1:0]  itm_len, dtm_len;
    logic        itm_ack, dtm_ack, dct_valid, test_has_ended;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
`ifdef NIOS2_OCI_DCT_STALL_COUNT_EN
    logic [15:0] dct_stall_count;
`endif

    int errors = 0;
    int checks = 0;

    nios2_system_nios2_oci_dct_sched dut (
        .clk(clk), .reset(reset),
        .itm_req(itm_req), .itm_data(itm_data), .itm_len(itm_len), .itm_ack(itm_ack),
        .dtm_req(dtm_req), .dtm_data(dtm_data), .dtm_len(dtm_len), .dtm_ack(dtm_ack),
        .flush_req(flush_req), .test_ending(test_ending),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
        .dct_ready(dct_ready), .test_has_ended(test_has_ended)
`ifdef NIOS2_OCI_DCT_STALL_COUNT_EN
       ,.dct_stall_count(dct_stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 accepting, 1 draining, 2 final drain, 3 ended.
    logic [1:0] m_q[$];
    int         m_mode = 0;
    bit         m_rr = 0;
    bit         m_endp = 0;
    int         m_stall = 0;
    bit         started = 0;

    function automatic void arb(output bit gi, output bit gd, output bit creq, output bit cfit,
                                output int clen, output logic [7:0] cdata);
        bit use_itm;
        use_itm = (m_rr == 0) ? itm_req : (itm_req && !dtm_req);
        creq  = itm_req || dtm_req;
        clen  = use_itm ? int'(itm_len) : int'(dtm_len);
        cdata = use_itm ? itm_data : dtm_data;
        cfit  = (m_q.size() + clen + 1) <= 15;
        gi = 0; gd = 0;
        if (m_mode == 0 && creq && cfit && !test_ending && !reset) begin
            gi = use_itm;
            gd = !use_itm;
        end
    endfunction

    function automatic logic [29:0] model_buf();
        logic [29:0] b = '0;
        for (int i = 0; i < m_q.size(); i++) b[2*i +: 2] = m_q[i];
        return b;
    endfunction

    always @(posedge clk) begin
        bit gi, gd, creq, cfit;
        int clen;
        logic [7:0] cdata;
        arb(gi, gd, creq, cfit, clen, cdata);
        if (reset) begin
            started = 1;
            m_q.delete();
            m_mode = 0; m_rr = 0; m_endp = 0; m_stall = 0;
        end else begin
            if ((itm_req || dtm_req) && !(gi || gd) && m_stall < 16'hFFFF) m_stall++;
            case (m_mode)
                0: begin
                    if (gi || gd) begin
                        for (int i = 0; i <= clen; i++) m_q.push_back(cdata[2*i +: 2]);
                        m_rr = gi;
                    end
                    if (test_ending) m_mode = (m_q.size() > 0) ? 2 : 3;
                    else if (m_q.size() == 15 || (creq && !cfit && m_q.size() > 0)
                             || (flush_req && m_q.size() > 0)) m_mode = 1;
                end
                1: begin
                    if (dct_ready) begin
                        m_q.delete();
                        m_mode = (m_endp || test_ending) ? 3 : 0;
                        m_endp = 0;
                    end else if (test_ending) m_endp = 1;
                end
                2: if (dct_ready) begin m_q.delete(); m_mode = 3; end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        bit gi, gd, creq, cfit;
        int clen;
        logic [7:0] cdata;
        if (started) begin
            arb(gi, gd, creq, cfit, clen, cdata);
            chk("itm_ack", itm_ack, gi);
            chk("dtm_ack", dtm_ack, gd);
            chk("dct_count", dct_count, m_q.size());
            chk("dct_buffer", dct_buffer, model_buf());
            chk("dct_valid", dct_valid, (m_mode == 1 || m_mode == 2));
            chk("test_has_ended", test_has_ended, (m_mode == 3));
`ifdef NIOS2_OCI_DCT_STALL_COUNT_EN
            chk("dct_stall_count", dct_stall_count, m_stall);
`endif
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [29:0] saved;

    initial begin
        reset = 1; itm_req = 0; dtm_req = 0; flush_req = 0; test_ending = 0; dct_ready = 0;
        itm_data = 0; dtm_data = 0; itm_len = 0; dtm_len = 0;
        tick(2);
        reset = 0;
        chk("reset_count", dct_count, 0);
        chk("reset_valid", dct_valid, 0);
        chk("reset_ended", test_has_ended, 0);

        // ITM-only packing
        itm_req = 1; itm_data = 8'hE4; itm_len = 3;
        #1 chk("itm_first_ack", itm_ack, 1);
        tick();
        itm_req = 0;
        chk("pack_count", dct_count, 4);
        chk("pack_byte", dct_buffer[7:0], 8'hE4);

        // Round robin, DTM is owed the next grant
        itm_req = 1; itm_data = 8'h01; itm_len = 0;
        dtm_req = 1; dtm_data = 8'h02; dtm_len = 0;
        #1 chk("rr_dtm_first", dtm_ack, 1);
        tick(11);
        chk("rr_full_count", dct_count, 15);
        chk("rr_full_valid", dct_valid, 1);
        chk("rr_slot4", dct_buffer[9:8], 2'b10);
        chk("rr_slot5", dct_buffer[11:10], 2'b01);
        chk("rr_no_ack", itm_ack | dtm_ack, 0);
        tick();
        itm_req = 0; dtm_req = 0; dct_ready = 1;
        tick();
        dct_ready = 0;
        chk("rr_drained", dct_count, 0);

        // No-fit flush at count 13
        itm_req = 1; itm_data = 8'h1B; itm_len = 3;
        tick(3);
        itm_len = 0;
        tick();
        chk("nofit_count13", dct_count, 13);
        itm_len = 3;
        #1 chk("nofit_no_ack", itm_ack, 0);
        tick();
        chk("nofit_valid", dct_valid, 1);
        saved = dct_buffer;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nofit_stable", dct_buffer, saved);
        end
        dct_ready = 1;
        tick();
        dct_ready = 0;
        tick();
        chk("nofit_after", dct_count, 4);
        itm_req = 0;

        // Partial flush, then flush request on an empty buffer
        itm_req = 1; itm_data = 8'h02; itm_len = 0;
        tick();
        itm_req = 0; flush_req = 1;
        tick();
        flush_req = 0;
        chk("pflush_valid", dct_valid, 1);
        chk("pflush_count", dct_count, 5);
        dct_ready = 1;
        tick();
        dct_ready = 0; flush_req = 1;
        tick();
        flush_req = 0;
        chk("empty_flush_ignored", dct_valid, 0);

        // End of test with a count of 7
        itm_req = 1; itm_data = 8'hE4; itm_len = 3;
        tick();
        itm_len = 2;
        tick();
        itm_req = 0; test_ending = 1;
        tick();
        test_ending = 0;
        chk("end_flush_valid", dct_valid, 1);
        chk("end_flush_count", dct_count, 7);
        dct_ready = 1;
        tick();
        dct_ready = 0;
        chk("ended_set", test_has_ended, 1);
        itm_req = 1; dtm_req = 1;
        tick(3);
        chk("ended_sticky", test_has_ended, 1);
        chk("ended_no_ack", itm_ack | dtm_ack, 0);
        itm_req = 0; dtm_req = 0;

        // End of test on an empty buffer
        reset = 1; tick(); reset = 0;
        test_ending = 1;
        tick();
        test_ending = 0;
        chk("empty_end_ended", test_has_ended, 1);
        chk("empty_end_valid", dct_valid, 0);

        // Reset while offering a buffer
        reset = 1; tick(); reset = 0;
        itm_req = 1; itm_len = 3; tick(); itm_req = 0;
        flush_req = 1; tick(); flush_req = 0;
        chk("pre_reset_valid", dct_valid, 1);
        reset = 1; tick(); reset = 0;
        chk("mid_reset_valid", dct_valid, 0);
        chk("mid_reset_count", dct_count, 0);
        chk("mid_reset_ended", test_has_ended, 0);

        // Blocked cycles while draining, then end-of-test latched in FLUSH
        itm_req = 1; itm_len = 3; tick(); itm_req = 0;
        flush_req = 1; tick(); flush_req = 0;
        itm_req = 1;
        tick(6);
        itm_req = 0;
`ifdef NIOS2_OCI_DCT_STALL_COUNT_EN
        chk("stall_six", dct_stall_count, 6);
`endif
        test_ending = 1; tick(); test_ending = 0;
        chk("latched_not_ended", test_has_ended, 0);
        dct_ready = 1; tick(); dct_ready = 0;
        chk("latched_end", test_has_ended, 1);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
